// File: rtl/pid_pkg.sv
// Shared types and helpers for the time-multiplexed PID controller.
package pid_pkg;
    localparam int ACC_W = 64;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MUL_P, S_MUL_I, S_MUL_D, S_SUM, S_DONE
    } state_t;

    typedef logic [7:0] axis_t;
    typedef logic signed [15:0] gain_t;

    function automatic logic signed [ACC_W-1:0] clamp_s(input logic signed [ACC_W-1:0] v,
                                                         input logic signed [ACC_W-1:0] lim);
        if (v > lim) return lim;
        else if (v < -lim) return -lim;
        else return v;
    endfunction

    function automatic logic is_clamped(input logic signed [ACC_W-1:0] v,
                                        input logic signed [ACC_W-1:0] lim);
        return (v > lim) || (v < -lim);
    endfunction
endpackage

// File: rtl/pid_deriv_hist.sv
// Per-axis circular error history; one shared pointer advanced once per sample.
module pid_deriv_hist #(
    parameter int N_AXES = 3,
    parameter int DEPTH  = 8,
    parameter int W      = 64,
    parameter int AX_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            we,
    input  logic            adv,
    input  logic [AX_W-1:0] sel,
    input  logic [W-1:0]    wdata,
    output logic [W-1:0]    oldest
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] ptr;
    logic [W-1:0]     mem [N_AXES][DEPTH];

    // Slot at ptr holds the entry written DEPTH samples ago; it is read before the write lands.
    assign oldest = mem[sel][ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            for (int a = 0; a < N_AXES; a++)
                for (int i = 0; i < DEPTH; i++)
                    mem[a][i] <= '0;
        end else begin
            if (clr) begin
                for (int a = 0; a < N_AXES; a++)
                    for (int i = 0; i < DEPTH; i++)
                        mem[a][i] <= '0;
            end else if (we) begin
                mem[sel][ptr] <= wdata;
            end
            if (adv) ptr <= ptr + PTR_W'(1);
        end
    end
endmodule

// File: rtl/pid_multi.sv
// N-axis PID rate controller sharing one gain multiplier, five cycles per axis.
module pid_multi
    import pid_pkg::*;
#(
    parameter int N_AXES       = 3,
    parameter int GYRO_W       = 16,
    parameter int STICK_W      = 12,
    parameter int OUT_W        = 13,
    parameter int FRAC         = 18,
    parameter int GAIN_FRAC    = 8,
    parameter int FS_DPS       = 1000,
    parameter int MAX_DPS      = 400,
    parameter int STICK_CENTER = 500,
    parameter int DERIV_DEPTH  = 8,
    parameter int I_MAX        = 1024,
    parameter int OUT_MAX      = 4095
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_AXES*GYRO_W-1:0]    gyro,
    input  logic [N_AXES*STICK_W-1:0]   stick,
    input  logic [N_AXES*16-1:0]        kp,
    input  logic [N_AXES*16-1:0]        ki,
    input  logic [N_AXES*16-1:0]        kd,
    input  logic                        arm,
    output logic                        out_valid,
    output logic [N_AXES*OUT_W-1:0]     power,
    output logic [N_AXES-1:0]           sat,
    output logic                        overrun
);
    localparam int AX_W  = (N_AXES > 1) ? $clog2(N_AXES) : 1;
    localparam int SHIFT = FRAC + GAIN_FRAC;
    localparam logic signed [ACC_W-1:0] CENTER  = ACC_W'(STICK_CENTER);
    localparam logic signed [ACC_W-1:0] RATE_K  = ACC_W'(FS_DPS) <<< (FRAC - 15);
    localparam logic signed [ACC_W-1:0] SP_GAIN = (ACC_W'(MAX_DPS) <<< FRAC) / (CENTER * CENTER);
    localparam logic signed [ACC_W-1:0] I_LIM   = ACC_W'(I_MAX) <<< FRAC;
    localparam logic signed [ACC_W-1:0] O_LIM   = ACC_W'(OUT_MAX);

    state_t state, state_nxt;
    axis_t  ax;
    logic [AX_W-1:0] ax_i;
    logic last_ax, accept;

    logic [N_AXES*GYRO_W-1:0]  gyro_r;
    logic [N_AXES*STICK_W-1:0] stick_r;
    logic [N_AXES*16-1:0]      kp_r, ki_r, kd_r;
    logic                      arm_r;
    logic signed [ACC_W-1:0]   integ [N_AXES];
    logic signed [ACC_W-1:0]   e_r, d_r, acc;
    logic [N_AXES*OUT_W-1:0]   pw_r;
    logic [N_AXES-1:0]         sat_r;

    logic signed [GYRO_W-1:0] gyro_a;
    logic [STICK_W-1:0]       stick_a;
    gain_t                    g_sel;
    logic signed [ACC_W-1:0]  rate, s, s_abs, sp, e_new, i_new, oldest, mul_a, prod, u, u_cl;
    logic                     freeze, u_sat;

    assign ax_i     = ax[AX_W-1:0];
    assign last_ax  = (ax == axis_t'(N_AXES - 1));
    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_MUL_P;
            S_MUL_P: state_nxt = S_MUL_I;
            S_MUL_I: state_nxt = S_MUL_D;
            S_MUL_D: state_nxt = S_SUM;
            S_SUM:   state_nxt = last_ax ? S_DONE : S_LOAD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Error, integrator update and the single shared gain multiplier for the current axis.
    always_comb begin
        gyro_a  = gyro_r[ax_i*GYRO_W +: GYRO_W];
        stick_a = stick_r[ax_i*STICK_W +: STICK_W];
        rate    = ACC_W'(gyro_a) * RATE_K;
        s       = $signed({{(ACC_W-STICK_W){1'b0}}, stick_a}) - CENTER;
        s_abs   = s[ACC_W-1] ? -s : s;
        sp      = s * s_abs * SP_GAIN;
        e_new   = sp - rate;
        // Hold the integrator while the last output was pinned in the direction e pushes.
        freeze  = sat[ax_i] && (e_new[ACC_W-1] == power[ax_i*OUT_W + OUT_W - 1]);
        i_new   = freeze ? integ[ax_i] : clamp_s(integ[ax_i] + e_new, I_LIM);
        mul_a   = '0;
        g_sel   = '0;
        case (state)
            S_MUL_P: begin mul_a = e_r;         g_sel = kp_r[ax_i*16 +: 16]; end
            S_MUL_I: begin mul_a = integ[ax_i]; g_sel = ki_r[ax_i*16 +: 16]; end
            S_MUL_D: begin mul_a = d_r;         g_sel = kd_r[ax_i*16 +: 16]; end
            default: ;
        endcase
        prod  = mul_a * ACC_W'(g_sel);
        u     = acc >>> SHIFT;
        u_cl  = clamp_s(u, O_LIM);
        u_sat = is_clamped(u, O_LIM);
    end

    pid_deriv_hist #(
        .N_AXES(N_AXES), .DEPTH(DERIV_DEPTH), .W(ACC_W), .AX_W(AX_W)
    ) u_hist (
        .clk(clk), .rst(rst),
        .clr(accept && !arm),
        .we(state == S_LOAD && arm_r),
        .adv(state == S_DONE),
        .sel(ax_i), .wdata(e_new), .oldest(oldest)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            power     <= '0;
            sat       <= '0;
            ax        <= '0;
            gyro_r    <= '0;
            stick_r   <= '0;
            kp_r      <= '0;
            ki_r      <= '0;
            kd_r      <= '0;
            arm_r     <= 1'b0;
            e_r       <= '0;
            d_r       <= '0;
            acc       <= '0;
            pw_r      <= '0;
            sat_r     <= '0;
            for (int a = 0; a < N_AXES; a++) integ[a] <= '0;
        end else begin
            out_valid <= (state == S_DONE);
            overrun   <= in_valid && !in_ready;
            case (state)
                S_IDLE: if (in_valid) begin
                    gyro_r  <= gyro;
                    stick_r <= stick;
                    kp_r    <= kp;
                    ki_r    <= ki;
                    kd_r    <= kd;
                    arm_r   <= arm;
                    ax      <= '0;
                    if (!arm) for (int a = 0; a < N_AXES; a++) integ[a] <= '0;
                end
                S_LOAD: begin
                    e_r <= e_new;
                    d_r <= e_new - oldest;
                    if (arm_r) integ[ax_i] <= i_new;
                end
                S_MUL_P: acc <= prod;
                S_MUL_I: acc <= acc + prod;
                S_MUL_D: acc <= acc + prod;
                S_SUM: begin
                    pw_r[ax_i*OUT_W +: OUT_W] <= arm_r ? u_cl[OUT_W-1:0] : '0;
                    sat_r[ax_i]               <= arm_r && u_sat;
                    if (!last_ax) ax <= ax + axis_t'(1);
                end
                S_DONE: begin
                    power <= pw_r;
                    sat   <= sat_r;
                end
                default: ;
            endcase
        end
    end
endmodule
